mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum bus wait cycles before abort.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  execute result present.
REQ-005 SHALL have port in_ready  output  1  stage accepts result this cycle.
REQ-006 SHALL have port in_op  input  2  0=none, 1=store, 2=load, 3=reserved (treated as none).
REQ-007 SHALL have port in_rd  input  4  destination register index.
REQ-008 SHALL have port in_w_req  input  1  execute requests register write.
REQ-009 SHALL have port in_x_rd  input  32  execute result for rd.
REQ-010 SHALL have port in_mem_addr  input  32  byte address, word aligned.
REQ-011 SHALL have port in_mem_val  input  32  store data.
REQ-012 SHALL have port bus_req, bus_we  output  1 each  bus request, write enable.
REQ-013 SHALL have port bus_addr, bus_wdata  output  32 each  address, write data.
REQ-014 SHALL have port bus_ack  input  1; bus_rdata  input  32  completion, read data.
REQ-015 SHALL have port wb_valid, wb_we  output  1 each  writeback pulse, register write enable.
REQ-016 SHALL have port wb_rd  output  4; wb_data  output  32  writeback target, value.
REQ-017 SHALL have port err  output  1  one-cycle bus-timeout pulse.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, RESP; in_ready=1 in IDLE and RESP, 0 in ACCESS.
REQ-019 SHALL accept on in_valid&&in_ready, latching all in_* fields.
REQ-020 SHALL go to RESP on accepted op none, to ACCESS on store/load, and to IDLE from RESP when nothing is accepted.
REQ-021 SHALL in ACCESS hold bus_req=1 with stable bus_we (1 store, 0 load), bus_addr and bus_wdata until the cycle bus_ack=1 is sampled.
REQ-022 SHALL ignore bus_ack while bus_req=0.
REQ-023 SHALL on ack: load latches bus_rdata into wb_data, store keeps in_x_rd; deassert bus_req next cycle; go to RESP.
REQ-024 SHALL in RESP drive wb_valid=1 for exactly one cycle; latency none=1 cycle, memory=ack cycle+1.
REQ-025 SHALL set wb_we = (in_w_req || load) && rd!=0; writes to register 0 are suppressed while wb_valid still pulses.
REQ-026 SHALL allow back-to-back: accept in RESP yields wb_valid on consecutive cycles for none ops.
REQ-027 SHALL count ACCESS cycles in an 8-bit counter; the counter SHALL NOT wrap.

Reset
REQ-028 SHALL on reset force IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, err=0, counter=0.
REQ-029 SHALL abandon an in-flight ACCESS on reset mid-transaction with no wb_valid; a late bus_ack SHALL be ignored.

Configuration
REQ-030 SHALL with MEM_STAGE_TIMEOUT_EN defined abort ACCESS after TIMEOUT_CYCLES cycles without ack: deassert bus_req, pulse err, go to RESP with wb_we=0, wb_data=0.
REQ-031 SHALL with MEM_STAGE_TIMEOUT_EN undefined wait indefinitely, hold err=0 and omit the counter.

Structure
REQ-032 SHALL place the MEM_OP enum (NONE/STORE/LOAD) and the state enum in shared package lib_cpu.
REQ-033 SHALL be a single module; the timeout counter is inline with no sub-module.

Verification
REQ-034 SHALL cover: none op, rd=3, x_rd=0x0000_0010, w_req=1 -> wb_valid next cycle, wb_we=1, wb_data=0x10.
REQ-035 SHALL cover: load addr 0x100, ack after 3 cycles with rdata 0xDEAD_BEEF -> bus_req high 3 cycles, wb_data=0xDEADBEEF, rd written.
REQ-036 SHALL cover: store addr 0x200, val 0x55 -> bus_we=1, bus_wdata=0x55 stable until ack, then wb_we=0 when w_req=0.
REQ-037 SHALL cover: load to rd=0 -> wb_valid=1, wb_we=0.
REQ-038 SHALL cover: MEM_STAGE_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack -> err pulse at cycle 4, bus_req dropped, wb_we=0.
REQ-039 SHALL cover: reset during ACCESS, then a stray ack -> all outputs 0 and no wb_valid.

Source files
------------

// File: rtl/lib_cpu_pkg.sv
// lib_cpu: shared CPU pipeline types (memory op encoding, MEM stage states)
// and the writeback-enable helper used by the MEM stage.
package lib_cpu;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_STORE = 2'd1,
        OP_LOAD  = 2'd2,
        OP_RSVD  = 2'd3
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Register 0 is hardwired, so a write to it is dropped even when requested.
    function automatic logic wb_we_f(input logic w_req, input logic is_load, input logic [3:0] rd);
        return (w_req || is_load) && (rd != 4'd0);
    endfunction

endpackage

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage -- issues one bus access per load/store and
// emits a one-cycle writeback pulse. Define MEM_STAGE_TIMEOUT_EN for bus-timeout abort.
module mem_stage
    import lib_cpu::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [3:0]  in_rd,
    input  logic        in_w_req,
    input  logic [31:0] in_x_rd,
    input  logic [31:0] in_mem_addr,
    input  logic [31:0] in_mem_val,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    state_e      state_r;
    logic        is_load_r;
    logic        w_req_r;
    logic [3:0]  rd_r;
    logic [31:0] x_rd_r;
    logic        accept_s;
    logic        is_mem_s;

`ifdef MEM_STAGE_TIMEOUT_EN
    // cnt_r holds the number of ACCESS cycles already spent without an ack.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_r;
`endif

    assign in_ready = (state_r != ST_ACCESS);

    // Handshake and op-class decode of the incoming execute result
    always_comb begin
        accept_s = in_valid && in_ready;
        if ((in_op == OP_STORE) || (in_op == OP_LOAD)) begin
            is_mem_s = 1'b1;
        end else begin
            is_mem_s = 1'b0;
        end
    end

    // Stage FSM with registered bus and writeback outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            is_load_r <= 1'b0;
            w_req_r   <= 1'b0;
            rd_r      <= 4'd0;
            x_rd_r    <= 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 4'd0;
            wb_data   <= 32'd0;
            err       <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            cnt_r     <= 8'd0;
`endif
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            err      <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (accept_s) begin
                        is_load_r <= (in_op == OP_LOAD);
                        w_req_r   <= in_w_req;
                        rd_r      <= in_rd;
                        x_rd_r    <= in_x_rd;
                        if (is_mem_s) begin
                            state_r   <= ST_ACCESS;
                            bus_req   <= 1'b1;
                            bus_we    <= (in_op == OP_STORE);
                            bus_addr  <= in_mem_addr;
                            bus_wdata <= in_mem_val;
`ifdef MEM_STAGE_TIMEOUT_EN
                            cnt_r     <= 8'd0;
`endif
                        end else begin
                            state_r  <= ST_RESP;
                            wb_valid <= 1'b1;
                            wb_we    <= wb_we_f(in_w_req, 1'b0, in_rd);
                            wb_rd    <= in_rd;
                            wb_data  <= in_x_rd;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (bus_ack) begin
                        state_r  <= ST_RESP;
                        bus_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_we    <= wb_we_f(w_req_r, is_load_r, rd_r);
                        wb_rd    <= rd_r;
                        wb_data  <= is_load_r ? bus_rdata : x_rd_r;
                    end
`ifdef MEM_STAGE_TIMEOUT_EN
                    else if (cnt_r == TO_LAST) begin
                        state_r  <= ST_RESP;
                        bus_req  <= 1'b0;
                        err      <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_rd    <= rd_r;
                        wb_data  <= 32'd0;
                    end else begin
                        cnt_r <= (cnt_r == 8'hFF) ? cnt_r : cnt_r + 8'd1;
                    end
`else
                    else begin
                        state_r <= ST_ACCESS;
                    end
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
